// File: rtl/axi_frame_tagger_if.sv
// axi_frame_tagger_if: AXI-Stream channel bundle shared by the tagger's input and output
//   tvalid : beat valid (source -> sink)
//   tready : sink ready (sink -> source)
//   tdata  : beat data, DATA_WIDTH bits
//   tlast  : frame end marker
interface axi_frame_tagger_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tlast;
    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/axi_frame_tagger.sv
// axi_frame_tagger: re-frames an AXI-Stream into fixed-length frames behind a 2-entry skid buffer
//   clk, sync_reset : single clock, synchronous active-high reset
//   frame_len       : beats per frame (0 = 2^CNT_WIDTH), latched on each frame's first beat
//   s_axis          : input stream (slave modport); tready = not skid-full
//   m_axis          : output stream (master modport); tlast tags the frame's last beat
//   frame_err       : one-cycle pulse on an upstream/count framing mismatch
//   err_cnt         : saturating mismatch count
// Optional checking: define AXI_FRAME_TAGGER_FRAME_ERR_EN to resync on upstream tlast and
// report mismatches; otherwise s_axis.tlast is ignored and frame_err/err_cnt are tied 0.
module axi_frame_tagger #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 sync_reset,
    input  logic [CNT_WIDTH-1:0] frame_len,
    axi_frame_tagger_if.slave    s_axis,
    axi_frame_tagger_if.master   m_axis,
    output logic                 frame_err,
    output logic [15:0]          err_cnt
);
    typedef enum logic {IDLE, RUN} state_t;
    localparam int BW = DATA_WIDTH + 1;
    localparam logic [CNT_WIDTH:0] FULL_LEN = {1'b1, {CNT_WIDTH{1'b0}}};
    localparam logic [CNT_WIDTH:0] CNT_ONE  = {{CNT_WIDTH{1'b0}}, 1'b1};
    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] len_q, len_d;
    logic [CNT_WIDTH:0]   beat_cnt_q, beat_cnt_d;
    logic [BW-1:0]        out_q, out_d, skid_q, skid_d;
    logic                 out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;
    logic [CNT_WIDTH-1:0] cur_len;
    logic [CNT_WIDTH:0]   eff_len, cnt_inc;
    logic                 accept, xfer, cnt_last, tag_last;
    assign accept  = s_axis.tvalid && !skid_vld_q;
    assign xfer    = out_vld_q && m_axis.tready;
    // The first beat of a frame uses the live frame_len; later beats use the latched copy.
    assign cur_len = (state_q == IDLE) ? frame_len : len_q;
    // One extra counter bit lets a length of 0 mean a full 2^CNT_WIDTH-beat frame.
    assign eff_len  = (cur_len == '0) ? FULL_LEN : {1'b0, cur_len};
    assign cnt_inc  = ((state_q == IDLE) ? '0 : beat_cnt_q) + CNT_ONE;
    assign cnt_last = (cnt_inc == eff_len);
`ifdef AXI_FRAME_TAGGER_FRAME_ERR_EN
    logic        err_q, err_d, mismatch;
    logic [15:0] err_cnt_q, err_cnt_d;
    // An upstream tlast ends the frame early (resync); a count-based end stays in force.
    assign tag_last = cnt_last || s_axis.tlast;
    assign mismatch = accept && (s_axis.tlast != cnt_last);
    assign err_d     = mismatch;
    assign err_cnt_d = (mismatch && err_cnt_q != 16'hFFFF) ? err_cnt_q + 16'd1 : err_cnt_q;
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end
    assign frame_err = err_q;
    assign err_cnt   = err_cnt_q;
`else
    logic unused_tlast;
    assign unused_tlast = s_axis.tlast;
    assign tag_last     = cnt_last;
    assign frame_err    = 1'b0;
    assign err_cnt      = '0;
`endif
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        beat_cnt_d = beat_cnt_q;
        if (accept) begin
            len_d      = cur_len;
            state_d    = tag_last ? IDLE : RUN;
            beat_cnt_d = tag_last ? '0 : cnt_inc;
        end
    end
    // Output register refills from the skid entry first; a full skid entry blocks accepts,
    // so it can never collide with a new beat.
    always_comb begin
        out_d      = out_q;
        out_vld_d  = out_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        if (!out_vld_q || xfer) begin
            out_vld_d  = skid_vld_q || accept;
            out_d      = skid_vld_q ? skid_q : (accept ? {tag_last, s_axis.tdata} : out_q);
            skid_vld_d = 1'b0;
        end else if (accept) begin
            skid_d     = {tag_last, s_axis.tdata};
            skid_vld_d = 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state_q    <= IDLE;
            len_q      <= '0;
            beat_cnt_q <= '0;
            out_q      <= '0;
            out_vld_q  <= 1'b0;
            skid_q     <= '0;
            skid_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            beat_cnt_q <= beat_cnt_d;
            out_q      <= out_d;
            out_vld_q  <= out_vld_d;
            skid_q     <= skid_d;
            skid_vld_q <= skid_vld_d;
        end
    end
    assign s_axis.tready = !skid_vld_q;
    assign m_axis.tvalid = out_vld_q;
    assign m_axis.tdata  = out_q[DATA_WIDTH-1:0];
    assign m_axis.tlast  = out_q[DATA_WIDTH];
endmodule

// File: tb/tb_axi_frame_tagger.sv
// tb_axi_frame_tagger: directed self-checking bench for axi_frame_tagger (CNT_WIDTH = 4)
module tb_axi_frame_tagger;
    localparam int DW = 32;
    localparam int CW = 4;
    logic          clk = 1'b0;
    logic          sync_reset = 1'b1;
    logic [CW-1:0] frame_len = 4'd4;
    logic          frame_err;
    logic [15:0]   err_cnt;
    int            vec = 0;
    int            miscmp = 0;
    logic [DW:0]   rx[$];
    int            rx_cyc[$];
    int            acc_cyc[$];
    int            ready_bad;
    int            hold_bad;
    int            err_pulses;
    axi_frame_tagger_if #(.DATA_WIDTH(DW)) s_if ();
    axi_frame_tagger_if #(.DATA_WIDTH(DW)) m_if ();
    axi_frame_tagger #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk),
        .sync_reset(sync_reset),
        .frame_len(frame_len),
        .s_axis(s_if),
        .m_axis(m_if),
        .frame_err(frame_err),
        .err_cnt(err_cnt)
    );
    always #5 clk = ~clk;
    // Streams n beats (data = base + index), records every output transfer; inputs change
    // and outputs are observed at the falling edge. Bounded by a cycle budget.
    task automatic run(input int n, input logic [DW-1:0] base, input bit bp,
                       input logic [63:0] tl_mask, input int chg_at, input logic [CW-1:0] chg_len);
        int          sent = 0;
        logic        stalled = 1'b0;
        logic [DW:0] held = '0;
        rx.delete();
        rx_cyc.delete();
        acc_cyc.delete();
        ready_bad  = 0;
        hold_bad   = 0;
        err_pulses = 0;
        for (int cyc = 0; cyc < 2000 && !(sent == n && rx.size() == n); cyc++) begin
            @(negedge clk);
            if (sent == chg_at) frame_len = chg_len;
            if (stalled && (!m_if.tvalid || {m_if.tlast, m_if.tdata} !== held)) hold_bad++;
            s_if.tvalid = (sent < n);
            s_if.tdata  = base + DW'(sent);
            s_if.tlast  = tl_mask[sent];
            m_if.tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (s_if.tready !== ((sent - rx.size()) < 2)) ready_bad++;
            if (frame_err === 1'b1) err_pulses++;
            stalled = m_if.tvalid && !m_if.tready;
            held    = {m_if.tlast, m_if.tdata};
            if (s_if.tvalid && s_if.tready) begin
                acc_cyc.push_back(cyc);
                sent++;
            end
            if (m_if.tvalid && m_if.tready) begin
                rx.push_back({m_if.tlast, m_if.tdata});
                rx_cyc.push_back(cyc);
            end
        end
        @(negedge clk);
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b1;
        if (frame_err === 1'b1) err_pulses++;
    endtask
    task automatic test_reset;
        sync_reset = 1'b1;
        repeat (2) @(negedge clk);
        vec++; if (m_if.tvalid !== 1'b0) begin miscmp++; $display("FAIL reset_tvalid got=%b exp=0", m_if.tvalid); end
        vec++; if (m_if.tlast !== 1'b0) begin miscmp++; $display("FAIL reset_tlast got=%b exp=0", m_if.tlast); end
        vec++; if (m_if.tdata !== 32'h0) begin miscmp++; $display("FAIL reset_tdata got=%h exp=0", m_if.tdata); end
        vec++; if (frame_err !== 1'b0) begin miscmp++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
        vec++; if (err_cnt !== 16'h0) begin miscmp++; $display("FAIL reset_err_cnt got=%h exp=0", err_cnt); end
        sync_reset = 1'b0;
        @(negedge clk);
        vec++; if (s_if.tready !== 1'b1) begin miscmp++; $display("FAIL reset_tready got=%b exp=1", s_if.tready); end
    endtask
    task automatic test_count_framing;
        logic [DW:0] exp;
        frame_len = 4'd4;
        run(12, 32'h100, 1'b0, 64'h0, -1, 4'd0);
        vec++; if (rx.size() !== 12) begin miscmp++; $display("FAIL count_size got=%0d exp=12", rx.size()); end
        for (int i = 0; i < 12; i++) begin
            exp = {(i % 4 == 3), 32'h100 + DW'(i)};
            vec++; if (rx[i] !== exp) begin miscmp++; $display("FAIL count_beat%0d got=%h exp=%h", i, rx[i], exp); end
        end
        vec++; if (rx_cyc[0] !== acc_cyc[0] + 1) begin miscmp++; $display("FAIL count_latency got=%0d exp=%0d", rx_cyc[0], acc_cyc[0] + 1); end
        vec++; if (rx_cyc[11] !== rx_cyc[0] + 11) begin miscmp++; $display("FAIL count_bubble got=%0d exp=%0d", rx_cyc[11], rx_cyc[0] + 11); end
    endtask
    task automatic test_backpressure;
        logic [DW:0] exp;
        frame_len = 4'd3;
        run(24, 32'h200, 1'b1, 64'h0, -1, 4'd0);
        vec++; if (rx.size() !== 24) begin miscmp++; $display("FAIL bp_size got=%0d exp=24", rx.size()); end
        for (int i = 0; i < 24; i++) begin
            exp = {(i % 3 == 2), 32'h200 + DW'(i)};
            vec++; if (rx[i] !== exp) begin miscmp++; $display("FAIL bp_beat%0d got=%h exp=%h", i, rx[i], exp); end
        end
        vec++; if (ready_bad !== 0) begin miscmp++; $display("FAIL bp_tready got=%0d bad cycles exp=0", ready_bad); end
        vec++; if (hold_bad !== 0) begin miscmp++; $display("FAIL bp_hold got=%0d bad cycles exp=0", hold_bad); end
    endtask
    task automatic test_len_one;
        frame_len = 4'd1;
        run(4, 32'h300, 1'b0, 64'h0, -1, 4'd0);
        vec++; if (rx.size() !== 4) begin miscmp++; $display("FAIL len1_size got=%0d exp=4", rx.size()); end
        for (int i = 0; i < 4; i++) begin
            vec++; if (rx[i] !== {1'b1, 32'h300 + DW'(i)}) begin miscmp++; $display("FAIL len1_beat%0d got=%h exp=%h", i, rx[i], {1'b1, 32'h300 + DW'(i)}); end
        end
    endtask
    task automatic test_len_zero;
        frame_len = 4'd0;
        run(16, 32'h400, 1'b0, 64'h0, -1, 4'd0);
        vec++; if (rx.size() !== 16) begin miscmp++; $display("FAIL len0_size got=%0d exp=16", rx.size()); end
        for (int i = 0; i < 16; i++) begin
            vec++; if (rx[i] !== {(i == 15), 32'h400 + DW'(i)}) begin miscmp++; $display("FAIL len0_beat%0d got=%h exp=%h", i, rx[i], {(i == 15), 32'h400 + DW'(i)}); end
        end
    endtask
    task automatic test_len_change;
        frame_len = 4'd5;
        run(9, 32'h480, 1'b0, 64'h0, 2, 4'd2);
        vec++; if (rx.size() !== 9) begin miscmp++; $display("FAIL chg_size got=%0d exp=9", rx.size()); end
        for (int i = 0; i < 9; i++) begin
            vec++; if (rx[i] !== {(i == 4 || i == 6 || i == 8), 32'h480 + DW'(i)}) begin miscmp++; $display("FAIL chg_beat%0d got=%h exp=%h", i, rx[i], {(i == 4 || i == 6 || i == 8), 32'h480 + DW'(i)}); end
        end
    endtask
    task automatic test_reset_mid;
        frame_len = 4'd4;
        run(2, 32'h500, 1'b0, 64'h0, -1, 4'd0);
        vec++; if (rx.size() !== 2 || rx[0] !== {1'b0, 32'h500} || rx[1] !== {1'b0, 32'h501}) begin miscmp++; $display("FAIL mid_pre got=%0d beats exp=2 untagged", rx.size()); end
        m_if.tready = 1'b0;
        s_if.tvalid = 1'b1;
        s_if.tdata  = 32'h502;
        @(negedge clk);
        s_if.tdata  = 32'h503;
        @(negedge clk);
        s_if.tvalid = 1'b0;
        vec++; if (s_if.tready !== 1'b0) begin miscmp++; $display("FAIL mid_skid_full_tready got=%b exp=0", s_if.tready); end
        vec++; if (m_if.tdata !== 32'h502) begin miscmp++; $display("FAIL mid_stalled_tdata got=%h exp=00000502", m_if.tdata); end
        sync_reset = 1'b1;
        @(negedge clk);
        vec++; if ({m_if.tvalid, m_if.tlast, m_if.tdata} !== 34'h0) begin miscmp++; $display("FAIL mid_reset_out got=%h exp=0", {m_if.tvalid, m_if.tlast, m_if.tdata}); end
        sync_reset  = 1'b0;
        m_if.tready = 1'b1;
        @(negedge clk);
        vec++; if (s_if.tready !== 1'b1) begin miscmp++; $display("FAIL mid_tready got=%b exp=1", s_if.tready); end
        run(4, 32'h600, 1'b0, 64'h0, -1, 4'd0);
        vec++; if (rx.size() !== 4) begin miscmp++; $display("FAIL mid_size got=%0d exp=4", rx.size()); end
        for (int i = 0; i < 4; i++) begin
            vec++; if (rx[i] !== {(i == 3), 32'h600 + DW'(i)}) begin miscmp++; $display("FAIL mid_beat%0d got=%h exp=%h", i, rx[i], {(i == 3), 32'h600 + DW'(i)}); end
        end
    endtask
    task automatic test_frame_err;
        logic [5:0] exp_last;
        int         exp_pulses;
        logic [15:0] exp_cnt;
        @(negedge clk);
        sync_reset = 1'b1;
        @(negedge clk);
        sync_reset = 1'b0;
        frame_len  = 4'd4;
        run(6, 32'h700, 1'b0, 64'h22, -1, 4'd0);
`ifdef AXI_FRAME_TAGGER_FRAME_ERR_EN
        exp_last   = 6'b100010;
        exp_pulses = 1;
        exp_cnt    = 16'd1;
`else
        exp_last   = 6'b001000;
        exp_pulses = 0;
        exp_cnt    = 16'd0;
`endif
        vec++; if (rx.size() !== 6) begin miscmp++; $display("FAIL err_size got=%0d exp=6", rx.size()); end
        for (int i = 0; i < 6; i++) begin
            vec++; if (rx[i] !== {exp_last[i], 32'h700 + DW'(i)}) begin miscmp++; $display("FAIL err_beat%0d got=%h exp=%h", i, rx[i], {exp_last[i], 32'h700 + DW'(i)}); end
        end
        vec++; if (err_pulses !== exp_pulses) begin miscmp++; $display("FAIL err_pulses got=%0d exp=%0d", err_pulses, exp_pulses); end
        vec++; if (err_cnt !== exp_cnt) begin miscmp++; $display("FAIL err_cnt got=%0d exp=%0d", err_cnt, exp_cnt); end
    endtask
    initial begin
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b1;
        test_reset();
        test_count_framing();
        test_backpressure();
        test_len_one();
        test_len_zero();
        test_len_change();
        test_reset_mid();
        test_frame_err();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
        $finish;
    end
endmodule
